mem_line_responder: RTL and testbench

Memory-side responder for the cache/arbiter line-transfer port (mem_enable / mem_rw / mem_addr / mem_data_in / mem_ack / mem_data_out). It accepts one line-wide read or write request at a time and holds it for a fixed, programmable latency. It then completes the request with a single-cycle mem_ack. It replaces the zero-latency memory model in CPU-level simulation, so that arbiter stalls and cache-miss timing are exercised.

---
 rtl/mem_line_responder_pkg.sv | 19 +
 rtl/mem_line_responder_if.sv | 23 ++
 rtl/mem_line_store.sv | 34 +++
 rtl/mem_line_responder.sv | 114 +++++++++++
 tb/tb_mem_line_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared encodings for the line responder: transfer direction, FSM states and
// the byte-offset width helper used to locate the line index inside mem_addr.
package mem_line_responder_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_BUSY    = 2'd1;
    localparam state_t S_ACK     = 2'd2;
    localparam state_t S_RELEASE = 2'd3;

    function automatic int line_off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Line-transfer port between a cache/arbiter (master) and the memory responder (slave).
interface mem_line_responder_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_in;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data_out;
    logic              busy;

    modport master (
        output mem_enable, mem_rw, mem_addr, mem_data_in,
        input  mem_ack, mem_data_out, busy
    );

    modport slave (
        input  mem_enable, mem_rw, mem_addr, mem_data_in,
        output mem_ack, mem_data_out, busy
    );
endinterface

// File: rtl/mem_line_store.sv
// DEPTH x LINE_W line storage with a single synchronous read/write port.
// The read register doubles as the responder's mem_data_out and is cleared by reset.
module mem_line_store #(
    parameter  int LINE_W = 128,
    parameter  int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    // Read data is held between reads so it stays valid after the ack cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: accepts one line read/write, holds it for LATENCY cycles,
// then completes it with a single-cycle mem_ack followed by a release handshake.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_responder_if.slave  bus
);

    localparam int OFF_W = line_off_w(LINE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rw_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  st_idx;
    logic              rd_en;
    logic              wr_en;
    logic              accept;
    logic              unused_addr;

    assign req_idx     = bus.mem_addr[OFF_W+IDX_W-1:OFF_W];
    assign unused_addr = ^bus.mem_addr;
    assign accept      = (state == S_IDLE) && bus.mem_enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mem_enable) begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= (LATENCY == 1) ? S_ACK : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!bus.mem_enable) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!bus.mem_enable) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Request fields are captured once at acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= bus.mem_rw;
            idx_q   <= req_idx;
            wdata_q <= bus.mem_data_in;
        end
    end

    // The read is issued on the edge that enters ACK so data lands with mem_ack.
    assign st_idx = (state == S_IDLE) ? req_idx : idx_q;
    assign rd_en  = bus.mem_enable &&
                    (((state == S_IDLE) && (LATENCY == 1) && (bus.mem_rw == MEM_READ)) ||
                     ((state == S_BUSY) && (cnt == CNT_W'(1)) && (rw_q == MEM_READ)));
    assign wr_en  = reset && (state == S_ACK) && (rw_q == MEM_WRITE);

    mem_line_store #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (st_idx),
        .wdata (wdata_q),
        .rdata (bus.mem_data_out)
    );

    assign bus.mem_ack = (state == S_ACK);
    assign bus.busy    = (state == S_BUSY) || (state == S_ACK);

    property p_stable_request;
        @(posedge clk) disable iff (!reset)
            ((state == S_BUSY) && bus.mem_enable) |-> ($stable(bus.mem_rw) && $stable(bus.mem_addr));
    endproperty

    a_stable_request: assert property (p_stable_request);

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed scenarios plus randomized traffic on a
// LATENCY=5 instance and a LATENCY=1 instance, checked against a line-array model.
module tb_mem_line_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic         en   [2];
    logic         rw   [2];
    logic [31:0]  addr [2];
    logic [127:0] din  [2];
    logic         ack  [2];
    logic         busy [2];
    logic [127:0] dout [2];

    mem_line_responder_if #(.ADDR_W(32), .LINE_W(128)) bus0 ();
    mem_line_responder_if #(.ADDR_W(32), .LINE_W(128)) bus1 ();

    mem_line_responder #(.ADDR_W(32), .LINE_W(128), .DEPTH(256), .LATENCY(5)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_line_responder #(.ADDR_W(32), .LINE_W(128), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    assign bus0.mem_enable  = en[0];
    assign bus0.mem_rw      = rw[0];
    assign bus0.mem_addr    = addr[0];
    assign bus0.mem_data_in = din[0];
    assign ack[0]           = bus0.mem_ack;
    assign busy[0]          = bus0.busy;
    assign dout[0]          = bus0.mem_data_out;

    assign bus1.mem_enable  = en[1];
    assign bus1.mem_rw      = rw[1];
    assign bus1.mem_addr    = addr[1];
    assign bus1.mem_data_in = din[1];
    assign ack[1]           = bus1.mem_ack;
    assign busy[1]          = bus1.busy;
    assign dout[1]          = bus1.mem_data_out;

    int lat [2] = '{5, 1};

    // Reference: line contents per (instance, line) and the last read result per instance.
    logic [127:0] model [int];
    logic [127:0] last_rd [2];

    int compared   = 0;
    int mismatched = 0;

    function automatic int key(input int s, input logic [31:0] a);
        return s * 1024 + int'((a / 32'd16) % 32'd256);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_req(input string tag, input int s, input logic w, input logic [31:0] a,
                          input logic [127:0] d, input int hold);
        int k_idx;
        logic [127:0] exp;
        k_idx = key(s, a);
        en[s] = 1'b1; rw[s] = w; addr[s] = a; din[s] = d;
        for (int k = 1; k <= lat[s]; k++) begin
            tick();
            if (k < lat[s]) begin
                chk({tag, "_early_ack"}, 128'(ack[s]), 128'(0));
                chk({tag, "_busy_wait"}, 128'(busy[s]), 128'(1));
            end
        end
        chk({tag, "_ack"}, 128'(ack[s]), 128'(1));
        chk({tag, "_busy_ack"}, 128'(busy[s]), 128'(1));
        if (w) begin
            chk({tag, "_dout_hold"}, dout[s], last_rd[s]);
            model[k_idx] = d;
        end else begin
            exp = model.exists(k_idx) ? model[k_idx] : 128'(0);
            last_rd[s] = exp;
            chk({tag, "_rdata"}, dout[s], exp);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_no_reserve"}, 128'(ack[s]), 128'(0));
            chk({tag, "_busy_release"}, 128'(busy[s]), 128'(0));
        end
        en[s] = 1'b0;
        addr[s] = $urandom;
        rw[s] = $urandom_range(0, 1);
        tick();
        chk({tag, "_ack_after"}, 128'(ack[s]), 128'(0));
        if (hold == 0) begin
            tick();
            chk({tag, "_idle_busy"}, 128'(busy[s]), 128'(0));
        end
    endtask

    task automatic do_abort(input string tag, input int s, input logic [31:0] a,
                            input logic [127:0] d, input int n);
        en[s] = 1'b1; rw[s] = 1'b1; addr[s] = a; din[s] = d;
        for (int k = 0; k < n; k++) begin
            tick();
            chk({tag, "_busy"}, 128'(busy[s]), 128'(1));
            chk({tag, "_ack"}, 128'(ack[s]), 128'(0));
        end
        en[s] = 1'b0;
        tick();
        chk({tag, "_busy_fall"}, 128'(busy[s]), 128'(0));
        chk({tag, "_no_ack"}, 128'(ack[s]), 128'(0));
        for (int k = 0; k < lat[s]; k++) begin
            tick();
            chk({tag, "_no_late_ack"}, 128'(ack[s]), 128'(0));
        end
    endtask

    logic [31:0]  ridx [8];
    logic [31:0]  ra;
    logic [127:0] rd;

    initial begin
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b0; rw[s] = 1'b0; addr[s] = '0; din[s] = '0; last_rd[s] = '0;
        end
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            chk("reset_ack", 128'(ack[s]), 128'(0));
            chk("reset_busy", 128'(busy[s]), 128'(0));
            chk("reset_dout", dout[s], 128'(0));
        end
        reset = 1'b1;
        tick();

        // Write then read with a different byte offset in the same line.
        do_req("t1_wr", 0, 1'b1, 32'h0000_0040, 128'hDEADBEEF_00000001_CAFEF00D_12345678, 0);
        do_req("t1_rd", 0, 1'b0, 32'h0000_0044, 128'h0, 0);
        chk("t1_const", dout[0], 128'hDEADBEEF_00000001_CAFEF00D_12345678);

        // Upper address bits alias onto the same line.
        do_req("t2_wra", 0, 1'b1, 32'h0000_0010, 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004, 0);
        do_req("t2_wrb", 0, 1'b1, 32'h0000_1010, 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004, 0);
        do_req("t2_rd", 0, 1'b0, 32'h0000_0010, 128'h0, 0);
        chk("t2_const", dout[0], 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004);

        // Aborted write leaves the line untouched.
        do_req("t3_pre", 0, 1'b1, 32'h0000_0080, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 0);
        do_abort("t3_abort", 0, 32'h0000_0080, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 2);
        do_req("t3_rd", 0, 1'b0, 32'h0000_0080, 128'h0, 0);
        chk("t3_const", dout[0], 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);

        // Enable held after ack: one pulse only, next request accepted afterwards.
        do_req("t4_hold", 0, 1'b0, 32'h0000_0010, 128'h0, 3);
        do_req("t4_next", 0, 1'b0, 32'h0000_0040, 128'h0, 0);

        // Reset while a write is in flight.
        en[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h0000_0080; din[0] = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
        tick();
        tick();
        chk("t5_busy_pre", 128'(busy[0]), 128'(1));
        reset = 1'b0;
        tick();
        chk("t5_ack", 128'(ack[0]), 128'(0));
        chk("t5_busy", 128'(busy[0]), 128'(0));
        chk("t5_dout", dout[0], 128'(0));
        chk("t5_dout1", dout[1], 128'(0));
        last_rd[0] = '0; last_rd[1] = '0;
        tick();
        chk("t5_no_accept", 128'(busy[0]), 128'(0));
        reset = 1'b1; en[0] = 1'b0;
        tick();
        chk("t5_idle", 128'(busy[0]), 128'(0));
        do_req("t5_rd", 0, 1'b0, 32'h0000_0088, 128'h0, 0);
        chk("t5_const", dout[0], 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);

        // LATENCY=1 instance: back-to-back requests at minimum spacing.
        do_req("t6_wr5", 1, 1'b1, 32'h0000_0050, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
        do_req("t6_wr6", 1, 1'b1, 32'h0000_0060, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 0);
        do_req("t6_rd5", 1, 1'b0, 32'h0000_0054, 128'h0, 0);
        do_req("t6_rd6", 1, 1'b0, 32'hFFF0_0060, 128'h0, 0);
        do_req("t6_rd5b", 1, 1'b0, 32'h0000_0050, 128'h0, 1);

        // Randomized traffic over a small set of lines on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 8; j++) begin
                ridx[j] = 32'($urandom_range(0, 255));
                ra = ($urandom & 32'hFFFF_F000) | (ridx[j] << 4) | 32'($urandom_range(0, 15));
                rd = {$urandom, $urandom, $urandom, $urandom};
                do_req("rnd_init", s, 1'b1, ra, rd, 0);
            end
            for (int j = 0; j < 20; j++) begin
                ra = ($urandom & 32'hFFFF_F000) | (ridx[$urandom_range(0, 7)] << 4) | 32'($urandom_range(0, 15));
                rd = {$urandom, $urandom, $urandom, $urandom};
                do_req("rnd_op", s, 1'($urandom_range(0, 1)), ra, rd, $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
